// File: rtl/fetch_pc_queue_pkg.sv
// Shared types for the fetch PC generator and its bundle queue.
// The bundle struct depends on XLEN/ISSUE_WIDTH, so fetchBundle_t is declared
// inside fetch_pc_queue where those parameters are in scope.
package fetch_pc_queue_pkg;

    // Generator state: running, draining after the PC limit, or fully halted.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetchState_t;

    // Every lane of a bundle covers one 32-bit instruction.
    localparam int LANE_BYTES = 4;

endpackage

// File: rtl/fetch_pc_queue_fifo.sv
// sync_fifo_flush: generic DEPTH-entry circular FIFO with pointer wrap,
// occupancy count and a synchronous flush. A push is accepted when there is
// room or when a pop happens in the same cycle.
module sync_fifo_flush #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage array; flushed pushes are dropped along with the rest of the queue.
    always_ff @(posedge clk) begin
        if (push_ok && !flush && !reset) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/fetch_pc_queue.sv
// fetch_pc_queue: front-end PC generator feeding a queue of ISSUE_WIDTH-lane
// fetch bundles. Supports consumer backpressure, redirect with a partial
// first-bundle lane mask, and halting once the bundle base passes PC_LIMIT.
module fetch_pc_queue
    import fetch_pc_queue_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              ISSUE_WIDTH = 2,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] PC_LIMIT    = XLEN'(120),
    localparam int             CW          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   deq_ready,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [ISSUE_WIDTH-1:0] out_lane_valid,
    output logic [CW-1:0]          count,
    output logic                   halted
);
    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [ISSUE_WIDTH-1:0] lane_valid;
    } fetchBundle_t;

    localparam logic [XLEN-1:0] BUNDLE_BYTES = XLEN'(LANE_BYTES * ISSUE_WIDTH);

    logic [XLEN-1:0]        pc_reg, pc_next;
    logic [ISSUE_WIDTH-1:0] mask_reg, mask_next;
    fetchState_t            state_reg, state_next;
    logic [CW-1:0]          count_next;

    logic                   enq, deq;
    logic                   fifo_empty, fifo_full;
    logic [CW-1:0]          fifo_count;
    fetchBundle_t           push_bundle, head_bundle;

    logic [XLEN-1:0]        redirect_base;
    logic [XLEN-1:0]        redirect_lane;
    logic [ISSUE_WIDTH-1:0] redirect_mask;

    // Redirect target aligned down to a bundle, plus the lane it lands on.
    assign redirect_base = redirect_pc & ~(BUNDLE_BYTES - XLEN'(1));
    assign redirect_lane = (redirect_pc >> 2) & XLEN'(ISSUE_WIDTH - 1);

    // Lanes before the landing lane are not part of the redirected stream.
    generate
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane_mask
            assign redirect_mask[gi] = (XLEN'(gi) >= redirect_lane);
        end
    endgenerate

    // Redirect hides the head and blocks both queue operations this cycle.
    assign out_valid = !fifo_empty && !redirect_valid;
    assign deq       = out_valid && deq_ready;
    assign enq       = (state_reg == RUN) && !redirect_valid && (!fifo_full || deq);

    assign push_bundle.pc         = pc_reg;
    assign push_bundle.lane_valid = mask_reg;

    sync_fifo_flush #(
        .WIDTH($bits(fetchBundle_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (enq),
        .push_data(push_bundle),
        .pop      (deq),
        .head_data(head_bundle),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    // Next PC/mask and next generator state, derived from where the PC and
    // the queue occupancy will be after this edge.
    always_comb begin
        pc_next    = pc_reg;
        mask_next  = mask_reg;
        count_next = fifo_count;
        if (redirect_valid) begin
            pc_next    = redirect_base;
            mask_next  = redirect_mask;
            count_next = '0;
        end else begin
            if (enq) begin
                pc_next   = pc_reg + BUNDLE_BYTES;
                mask_next = '1;
            end
            count_next = fifo_count + CW'(enq) - CW'(deq);
        end
        if (pc_next > PC_LIMIT) begin
            state_next = (count_next == '0) ? HALT : DRAIN;
        end else begin
            state_next = RUN;
        end
    end

    // Generator registers; reset takes priority over a coincident redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            mask_reg  <= '1;
            state_reg <= RUN;
        end else begin
            pc_reg    <= pc_next;
            mask_reg  <= mask_next;
            state_reg <= state_next;
        end
    end

    assign out_pc         = out_valid ? head_bundle.pc : '0;
    assign out_lane_valid = out_valid ? head_bundle.lane_valid : '0;
    assign count          = fifo_count;
    assign halted         = (state_reg == HALT);

endmodule
